// File: rtl/sram_bus_master.sv
// rtl/sram_bus_master.sv - single-access initiator for an asynchronous SRAM with programmable setup/strobe/hold
module sram_bus_master #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Req,
  input  logic              i_Wr,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [DATA_W-1:0] i_WData,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [DATA_W-1:0] o_RData,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [DATA_W-1:0] o_Data_Out,
  output logic              o_Data_OE,
  input  logic [DATA_W-1:0] i_Data_In,
  output logic              o_WE,
  output logic              o_OE,
  output logic              o_CE,
  output logic              o_CE2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The phase counter is loaded with length-1 so that it reads zero in the last cycle of a phase.
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       wr_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      wr_q       <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      o_RData    <= '0;
      o_Addr     <= '0;
      o_Data_Out <= '0;
      o_Data_OE  <= 1'b0;
      o_WE       <= 1'b1;
      o_OE       <= 1'b1;
      o_CE       <= 1'b1;
      o_CE2      <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Req) begin
            state     <= SETUP;
            cnt       <= SETUP_LD;
            wr_q      <= i_Wr;
            o_Busy    <= 1'b1;
            o_Addr    <= i_Addr;
            o_Data_OE <= i_Wr;
            o_CE      <= 1'b0;
            o_CE2     <= 1'b1;
            if (i_Wr) begin
              o_Data_Out <= i_WData;
            end
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state <= STROBE;
            cnt   <= STROBE_LD;
            o_WE  <= ~wr_q;
            o_OE  <= wr_q;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STROBE: begin
          if (cnt == 8'd0) begin
            state <= HOLD;
            cnt   <= HOLD_LD;
            o_WE  <= 1'b1;
            o_OE  <= 1'b1;
            // The SRAM is still driving the bus at this edge, so read data is taken here.
            if (!wr_q) begin
              o_RData <= i_Data_In;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state     <= IDLE;
            o_Busy    <= 1'b0;
            o_Done    <= 1'b1;
            o_Data_OE <= 1'b0;
            o_CE      <= 1'b1;
            o_CE2     <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_master.sv
// tb/tb_sram_bus_master.sv - scoreboard bench for sram_bus_master with two timing configurations
module tb_sram_bus_master;

  localparam int AW = 15;
  localparam int DW = 8;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            start;
    bit            abort;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic          req    [2];
  logic          wr     [2];
  logic [AW-1:0] addr_i [2];
  logic [DW-1:0] wdata  [2];
  logic          busy   [2];
  logic          done   [2];
  logic [DW-1:0] rdata  [2];
  logic [AW-1:0] addr_o [2];
  logic [DW-1:0] dout   [2];
  logic          doe    [2];
  logic [DW-1:0] din    [2];
  logic          we     [2];
  logic          oe     [2];
  logic          ce     [2];
  logic          ce2    [2];

  sram_bus_master dut0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req[0]), .i_Wr(wr[0]),
    .i_Addr(addr_i[0]), .i_WData(wdata[0]), .o_Busy(busy[0]), .o_Done(done[0]),
    .o_RData(rdata[0]), .o_Addr(addr_o[0]), .o_Data_Out(dout[0]), .o_Data_OE(doe[0]),
    .i_Data_In(din[0]), .o_WE(we[0]), .o_OE(oe[0]), .o_CE(ce[0]), .o_CE2(ce2[0])
  );

  sram_bus_master #(.SETUP_CYC(3), .STROBE_CYC(5), .HOLD_CYC(2)) dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req[1]), .i_Wr(wr[1]),
    .i_Addr(addr_i[1]), .i_WData(wdata[1]), .o_Busy(busy[1]), .o_Done(done[1]),
    .o_RData(rdata[1]), .o_Addr(addr_o[1]), .o_Data_Out(dout[1]), .o_Data_OE(doe[1]),
    .i_Data_In(din[1]), .o_WE(we[1]), .o_OE(oe[1]), .o_CE(ce[1]), .o_CE2(ce2[1])
  );

  // Behavioural SRAMs: write on an edge while selected with WE low, drive data while OE low.
  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  assign din[0] = (!ce[0] && !oe[0]) ? mem0[addr_o[0]] : 8'h00;
  assign din[1] = (!ce[1] && !oe[1]) ? mem1[addr_o[1]] : 8'h00;
  always @(posedge clk) begin
    if (!ce[0] && ce2[0] && !we[0]) mem0[addr_o[0]] <= dout[0];
    if (!ce[1] && ce2[1] && !we[1]) mem1[addr_o[1]] <= dout[1];
  end

  int vectors = 0;
  int miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];
  int pending  [2] = '{0, 0};
  int exp_done [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int idle_bad [2] = '{0, 0};

  task automatic chk(input int c, input string name, input logic [31:0] act, input logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL ch%0d %s: got %0h expected %0h (cycle %0d)", c, name, act, req_v, cyc);
    end
  endtask

  task automatic push(input int c, input exp_t e);
    if (c == 0) q0.push_back(e);
    else q1.push_back(e);
    pending[c]++;
    if (!e.abort) exp_done[c]++;
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pop(input int c, output exp_t e);
    if (c == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  function automatic logic [DW-1:0] mem_rd(input int c, input logic [AW-1:0] a);
    return (c == 0) ? mem0[a] : mem1[a];
  endfunction

  // Per-channel timing: setup/strobe/hold lengths.
  function automatic int t_setup(input int c);  return (c == 0) ? 1 : 3; endfunction
  function automatic int t_strobe(input int c); return (c == 0) ? 2 : 5; endfunction
  function automatic int t_hold(input int c);   return (c == 0) ? 1 : 2; endfunction

  exp_t cur       [2];
  bit   in_txn    [2] = '{0, 0};
  int   bcnt      [2];
  int   scnt      [2];
  int   sstart    [2];
  int   bad       [2];
  logic prev_busy [2] = '{0, 0};

  task automatic finish_txn(input int c);
    int total;
    total = t_setup(c) + t_strobe(c) + t_hold(c);
    chk(c, "busy_len", bcnt[c], total);
    chk(c, "strobe_start", sstart[c], t_setup(c) + 1);
    chk(c, "strobe_len", scnt[c], t_strobe(c));
    chk(c, "phase_errs", bad[c], 0);
    chk(c, "done_after_busy", {31'd0, prev_busy[c]}, 1);
    chk(c, "done_at", cyc, cur[c].start + total);
    if (cur[c].wr) chk(c, "sram_contents", {24'd0, mem_rd(c, cur[c].addr)}, {24'd0, cur[c].data});
    else chk(c, "rdata", {24'd0, rdata[c]}, {24'd0, cur[c].data});
    in_txn[c] = 0;
    pending[c]--;
    done_cnt[c]++;
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        if (in_txn[c]) begin
          chk(c, "abort_expected", {31'd0, cur[c].abort}, 1);
          in_txn[c] = 0;
          pending[c]--;
        end
      end else begin
        if (done[c]) begin
          if (in_txn[c]) finish_txn(c);
          else chk(c, "spurious_done", 1, 0);
        end
        if (busy[c]) begin
          if (!in_txn[c]) begin
            in_txn[c] = 1;
            bcnt[c] = 0; scnt[c] = 0; sstart[c] = 0; bad[c] = 0;
            if (qsize(c) == 0) begin
              chk(c, "unexpected_access", 1, 0);
              cur[c] = '{wr: 1'b0, addr: '0, data: '0, start: 0, abort: 1'b0};
            end else begin
              pop(c, cur[c]);
              chk(c, "accept_cycle", cyc, cur[c].start);
            end
          end
          bcnt[c]++;
          if (cur[c].wr ? !we[c] : !oe[c]) begin
            scnt[c]++;
            if (sstart[c] == 0) sstart[c] = bcnt[c];
          end
          if (ce[c] !== 1'b0 || ce2[c] !== 1'b1) bad[c]++;
          if (addr_o[c] !== cur[c].addr) bad[c]++;
          if (doe[c] !== cur[c].wr) bad[c]++;
          if (!we[c] && !oe[c]) bad[c]++;
          if (cur[c].wr && (dout[c] !== cur[c].data || !oe[c])) bad[c]++;
          if (!cur[c].wr && !we[c]) bad[c]++;
        end else begin
          if (ce[c] !== 1'b1 || ce2[c] !== 1'b0 || we[c] !== 1'b1 || oe[c] !== 1'b1 || doe[c] !== 1'b0)
            idle_bad[c]++;
        end
      end
      prev_busy[c] = busy[c];
    end
  end

  task automatic issue(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] rexp, input bit ab);
    @(posedge clk); #1;
    req[c] = 1'b1; wr[c] = w; addr_i[c] = a; wdata[c] = d;
    push(c, '{wr: w, addr: a, data: (w ? d : rexp), start: cyc + 1, abort: ab});
    @(posedge clk); #1;
    req[c] = 1'b0;
  endtask

  task automatic wait_drain(input int c);
    for (int t = 0; t < 100 && pending[c] != 0; t++) @(posedge clk);
    chk(c, "drain", pending[c], 0);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      req[c] = 1'b1; wr[c] = 1'b1; addr_i[c] = 15'h7FFF; wdata[c] = 8'hFF;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk(c, "rst_ce", {31'd0, ce[c]}, 1);
      chk(c, "rst_ce2", {31'd0, ce2[c]}, 0);
      chk(c, "rst_we", {31'd0, we[c]}, 1);
      chk(c, "rst_oe", {31'd0, oe[c]}, 1);
      chk(c, "rst_busy", {31'd0, busy[c]}, 0);
      chk(c, "rst_done", {31'd0, done[c]}, 0);
      chk(c, "rst_data_oe", {31'd0, doe[c]}, 0);
      chk(c, "rst_rdata", {24'd0, rdata[c]}, 0);
      chk(c, "rst_addr", {17'd0, addr_o[c]}, 0);
      chk(c, "rst_dout", {24'd0, dout[c]}, 0);
      req[c] = 1'b0;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk(0, "no_access_after_rst", {31'd0, busy[0]}, 0);

    // Default timing: write then read-back.
    issue(0, 1'b1, 15'h1234, 8'hA5, 8'h00, 1'b0);
    wait_drain(0);
    issue(0, 1'b0, 15'h1234, 8'h00, 8'hA5, 1'b0);
    wait_drain(0);

    // Stretched timing on the second instance.
    issue(1, 1'b1, 15'h0055, 8'h3C, 8'h00, 1'b0);
    wait_drain(1);
    issue(1, 1'b0, 15'h0055, 8'h00, 8'h3C, 1'b0);
    wait_drain(1);

    // Request held for 12 cycles while inputs wander; only cycles 0, 5 and 10 are accepted.
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      req[0] = 1'b1;
      wr[0] = (i % 5 == 0) ? 1'b1 : i[0];
      addr_i[0] = 15'h0100 + 15'(i);
      wdata[0] = 8'h10 + 8'(i);
      if (i % 5 == 0)
        push(0, '{wr: 1'b1, addr: 15'h0100 + 15'(i), data: 8'h10 + 8'(i), start: cyc + 1, abort: 1'b0});
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    wait_drain(0);
    issue(0, 1'b0, 15'h0100, 8'h00, 8'h10, 1'b0);
    wait_drain(0);
    issue(0, 1'b0, 15'h0105, 8'h00, 8'h15, 1'b0);
    wait_drain(0);
    issue(0, 1'b0, 15'h010A, 8'h00, 8'h1A, 1'b0);
    wait_drain(0);

    // Abort a write with reset during its second strobe cycle.
    issue(0, 1'b1, 15'h0200, 8'h77, 8'h00, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk(0, "abort_we", {31'd0, we[0]}, 1);
    chk(0, "abort_ce", {31'd0, ce[0]}, 1);
    chk(0, "abort_done", {31'd0, done[0]}, 0);
    chk(0, "abort_rdata", {24'd0, rdata[0]}, 0);
    rst_n = 1'b1;
    wait_drain(0);
    issue(0, 1'b1, 15'h0300, 8'h5A, 8'h00, 1'b0);
    wait_drain(0);
    issue(0, 1'b0, 15'h0300, 8'h00, 8'h5A, 1'b0);
    wait_drain(0);

    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk(c, "idle_pins", idle_bad[c], 0);
      chk(c, "done_count", done_cnt[c], exp_done[c]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
